// File: rtl/mem_store_buffer_if.sv
// Pipeline-side and DataMemory-side signals of the posted-store buffer.
// The buffer is the slave; the pipeline/memory environment is the master.
interface mem_store_buffer_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          StValid;
  logic          StReady;
  logic [AW-1:0] StAddress;
  logic [DW-1:0] StData;
  logic          LdValid;
  logic [AW-1:0] LdAddress;
  logic          LdHit;
  logic          LdStall;
  logic [DW-1:0] LdData;
  logic          Flush;
  logic          FlushDone;
  logic [AW-1:0] MemAddress;
  logic [DW-1:0] MemWriteData;
  logic          MemRead;
  logic          MemWrite;

  modport master (
    output StValid, StAddress, StData, LdValid, LdAddress, Flush,
    input  StReady, LdHit, LdStall, LdData, FlushDone,
    input  MemAddress, MemWriteData, MemRead, MemWrite
  );

  modport slave (
    input  StValid, StAddress, StData, LdValid, LdAddress, Flush,
    output StReady, LdHit, LdStall, LdData, FlushDone,
    output MemAddress, MemWriteData, MemRead, MemWrite
  );
endinterface

// File: rtl/mem_store_buffer.sv
// Posted-store FIFO between EX/MEM and DataMemory: loads forward from queued
// stores or go to memory; stores drain whenever a load does not need the port.
module mem_store_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  mem_store_buffer_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [AW-1:0] NEG3 = ~AW'(2);

  logic [AW-1:0] ent_addr [DEPTH];
  logic [DW-1:0] ent_data [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;

  logic          push;
  logic          pop;
  logic          hit;
  logic          conflict;
  logic          ld_miss;
  logic [DW-1:0] fwd_data;
  logic [PW-1:0] idx;
  logic [AW-1:0] diff;

  // Scan oldest to youngest so the last exact match is the youngest one.
  always_comb begin
    hit      = 1'b0;
    conflict = 1'b0;
    fwd_data = '0;
    idx      = '0;
    diff     = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx  = rd_ptr + PW'(i);
      diff = ent_addr[idx] - bus.LdAddress;
      if (CW'(i) < count) begin
        if (diff == '0) begin
          hit      = 1'b1;
          fwd_data = ent_data[idx];
        end else if (diff <= AW'(3) || diff >= NEG3) begin
          conflict = 1'b1;
        end
      end
    end
  end

  assign ld_miss = bus.LdValid & ~hit & ~conflict;
  assign push    = bus.StValid & bus.StReady;
  // Outputs are gated by rst_n so they sit at their reset values while reset is held.
  assign pop     = rst_n & ~ld_miss & (count != '0);

  assign bus.StReady      = (count != CW'(DEPTH));
  assign bus.MemRead      = rst_n & ld_miss;
  assign bus.MemWrite     = pop;
  assign bus.MemAddress   = (rst_n & ld_miss) ? bus.LdAddress :
                            pop               ? ent_addr[rd_ptr] : '0;
  assign bus.MemWriteData = pop ? ent_data[rd_ptr] : '0;
  assign bus.LdHit        = rst_n & bus.LdValid & hit;
  assign bus.LdStall      = rst_n & bus.LdValid & ~hit & conflict;
  assign bus.LdData       = bus.LdHit ? fwd_data : '0;
  assign bus.FlushDone    = rst_n & bus.Flush & (count == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      ent_addr[wr_ptr] <= bus.StAddress;
      ent_data[wr_ptr] <= bus.StData;
    end
  end
endmodule

// File: tb/tb_mem_store_buffer.sv
// Directed bench for mem_store_buffer: stimulus queues expected port activity,
// a negedge monitor compares every active DataMemory/forwarding cycle.
module tb_mem_store_buffer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;

  mem_store_buffer_if #(.AW(32), .DW(32)) bus ();

  mem_store_buffer #(.DEPTH(4), .AW(32), .DW(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        mw;
    logic        mr;
    logic        hit;
    logic        stall;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] ldata;
  } ev_t;

  ev_t expq[$];
  int  n_pass  = 0;
  int  n_total = 0;
  int  ev_num  = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic ev(input logic mw, input logic mr, input logic hit, input logic stall,
                    input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] ldata);
    ev_t e;
    e.mw = mw; e.mr = mr; e.hit = hit; e.stall = stall;
    e.addr = addr; e.wdata = wdata; e.ldata = ldata;
    expq.push_back(e);
  endtask

  // Monitor: fields are {MemWrite, MemRead, LdHit, LdStall, MemAddress, MemWriteData, LdData}
  always @(negedge clk) begin
    if (rst_n && (bus.MemWrite || bus.MemRead || bus.LdHit || bus.LdStall)) begin
      ev_t e;
      ev_num++;
      if (expq.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_event %0d: got mw=%0b mr=%0b hit=%0b stall=%0b addr=%0h expected no activity",
                 ev_num, bus.MemWrite, bus.MemRead, bus.LdHit, bus.LdStall, bus.MemAddress);
      end else begin
        e = expq.pop_front();
        check($sformatf("event_%0d", ev_num),
              {28'd0, bus.MemWrite, bus.MemRead, bus.LdHit, bus.LdStall,
               bus.MemAddress, bus.MemWriteData, bus.LdData},
              {28'd0, e.mw, e.mr, e.hit, e.stall, e.addr, e.wdata, e.ldata});
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic st(input logic [31:0] a, input logic [31:0] d);
    bus.StValid = 1'b1; bus.StAddress = a; bus.StData = d;
  endtask

  task automatic st_off();
    bus.StValid = 1'b0;
  endtask

  task automatic ld(input logic [31:0] a);
    bus.LdValid = 1'b1; bus.LdAddress = a;
  endtask

  task automatic ld_off();
    bus.LdValid = 1'b0;
  endtask

  initial begin
    bus.StValid = 1'b0; bus.StAddress = '0; bus.StData = '0;
    bus.LdValid = 1'b0; bus.LdAddress = '0; bus.Flush = 1'b0;
    #12 rst_n = 1'b1;

    // Reset mid-activity with three queued stores
    cyc(); ld(32'h200); st(100, 1); ev(0, 1, 0, 0, 32'h200, 0, 0);
    cyc(); st(104, 2); ev(0, 1, 0, 0, 32'h200, 0, 0);
    cyc(); st(108, 3); ev(0, 1, 0, 0, 32'h200, 0, 0);
    cyc(); st_off(); ev(0, 1, 0, 0, 32'h200, 0, 0);
    @(negedge clk); #1;
    bus.Flush = 1'b1; rst_n = 1'b0;
    #1;
    check("reset_flags", {122'd0, bus.StReady, bus.MemRead, bus.MemWrite, bus.LdHit, bus.LdStall, bus.FlushDone},
          {122'd0, 6'b100000});
    check("reset_mem_bus", {64'd0, bus.MemAddress, bus.MemWriteData}, 128'd0);
    check("reset_lddata", {96'd0, bus.LdData}, 128'd0);
    #1 ld_off();
    #1 rst_n = 1'b1;
    cyc(); #1;
    check("post_reset_ready", {127'd0, bus.StReady}, 128'd1);
    check("post_reset_empty", {126'd0, bus.FlushDone, bus.MemWrite}, {126'd0, 2'b10});
    bus.Flush = 1'b0;

    // Fill to full behind a held MISS load
    cyc(); ld(32'h300); st(0, 32'hA0); #1 check("fill_ready_0", {127'd0, bus.StReady}, 128'd1);
    ev(0, 1, 0, 0, 32'h300, 0, 0);
    cyc(); st(4, 32'hA1); ev(0, 1, 0, 0, 32'h300, 0, 0);
    cyc(); st(8, 32'hA2); ev(0, 1, 0, 0, 32'h300, 0, 0);
    cyc(); st(12, 32'hA3); #1 check("fill_ready_3", {127'd0, bus.StReady}, 128'd1);
    ev(0, 1, 0, 0, 32'h300, 0, 0);
    cyc(); st(16, 32'hA4); #1 check("full_not_ready", {127'd0, bus.StReady}, 128'd0);
    ev(0, 1, 0, 0, 32'h300, 0, 0);
    cyc(); ld_off(); #1 check("full_pop_no_push", {127'd0, bus.StReady}, 128'd0);
    ev(1, 0, 0, 0, 0, 32'hA0, 0);
    cyc(); #1 check("ready_after_pop", {127'd0, bus.StReady}, 128'd1);
    ev(1, 0, 0, 0, 4, 32'hA1, 0);
    cyc(); st_off(); ev(1, 0, 0, 0, 8, 32'hA2, 0);
    cyc(); ev(1, 0, 0, 0, 12, 32'hA3, 0);
    cyc(); ev(1, 0, 0, 0, 16, 32'hA4, 0);
    cyc(); #1 check("idle_after_drain", {95'd0, bus.MemWrite, bus.MemAddress}, 128'd0);

    // Forward youngest match while draining the older store
    cyc(); ld(32'h400); st(16, 100); ev(0, 1, 0, 0, 32'h400, 0, 0);
    cyc(); st(16, 200); ev(0, 1, 0, 0, 32'h400, 0, 0);
    cyc(); st_off(); ld(16); ev(1, 0, 1, 0, 16, 100, 200);
    cyc(); ld_off(); ev(1, 0, 0, 0, 16, 200, 0);

    // Partial-overlap conflict, above and at the 3-byte boundary
    cyc(); ld(32'h500); st(30, 6); ev(0, 1, 0, 0, 32'h500, 0, 0);
    cyc(); st_off(); ld(28); ev(1, 0, 0, 1, 30, 6, 0);
    cyc(); ev(0, 1, 0, 0, 28, 0, 0);
    cyc(); ld(32'h500); st(30, 7); ev(0, 1, 0, 0, 32'h500, 0, 0);
    cyc(); st_off(); ld(33); ev(1, 0, 0, 1, 30, 7, 0);
    cyc(); ld_off();

    // MISS load owns the port; queued stores wait, then drain back to back
    cyc(); ld(32'h600); st(44, 32'h11); ev(0, 1, 0, 0, 32'h600, 0, 0);
    cyc(); st(52, 32'h22); ev(0, 1, 0, 0, 32'h600, 0, 0);
    cyc(); st_off(); ld(40); ev(0, 1, 0, 0, 40, 0, 0);
    cyc(); ev(0, 1, 0, 0, 40, 0, 0);
    cyc(); ld_off(); ev(1, 0, 0, 0, 44, 32'h11, 0);
    cyc(); ev(1, 0, 0, 0, 52, 32'h22, 0);
    cyc(); #1 check("arb_idle", {127'd0, bus.MemWrite}, 128'd0);

    // Flush with three entries spanning a pointer wrap
    cyc(); ld(32'h700); st(60, 1); ev(0, 1, 0, 0, 32'h700, 0, 0);
    cyc(); st(64, 2); ev(0, 1, 0, 0, 32'h700, 0, 0);
    cyc(); st(68, 3); ev(0, 1, 0, 0, 32'h700, 0, 0);
    cyc(); st_off(); ld_off(); bus.Flush = 1'b1; #1 check("flush_busy_3", {127'd0, bus.FlushDone}, 128'd0);
    ev(1, 0, 0, 0, 60, 1, 0);
    cyc(); #1 check("flush_busy_2", {127'd0, bus.FlushDone}, 128'd0);
    ev(1, 0, 0, 0, 64, 2, 0);
    cyc(); #1 check("flush_busy_1", {127'd0, bus.FlushDone}, 128'd0);
    ev(1, 0, 0, 0, 68, 3, 0);
    cyc(); #1 check("flush_done", {127'd0, bus.FlushDone}, 128'd1);
    cyc(); bus.Flush = 1'b0; #1 check("flush_released", {127'd0, bus.FlushDone}, 128'd0);

    cyc(); cyc();
    check("events_outstanding", 128'(expq.size()), 128'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
